// File: rtl/iterative_muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package iterative_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'd0,
    MD_DIVU  = 2'd1,
    MD_MULT  = 2'd2,
    MD_DIV   = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/iterative_muldiv_unit_core.sv
// Shift datapath for the multiply/divide unit: accumulator, shift register and
// stored multiplier/divisor. One multiplier bit or quotient bit per step; no FSM.
//   mul: {acc, sreg} holds {partial high, multiplier -> product low}
//   div: acc is the running remainder, sreg shifts dividend out / quotient in
module iterative_muldiv_unit_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] sreg_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] sreg_o,
  output logic [WIDTH-1:0] b_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [WIDTH-1:0] div_diff;

  // The carry out of the add becomes the new top bit as the pair shifts right.
  assign mul_sum   = {1'b0, acc_q} + (sreg_q[0] ? {1'b0, b_q} : '0);
  assign div_shift = {acc_q, sreg_q[WIDTH-1]};
  assign div_fits  = (div_shift >= {1'b0, b_q});
  // When the divisor fits the true difference is below 2^WIDTH, so the low bits suffice.
  assign div_diff  = div_shift[WIDTH-1:0] - b_q;

  // Next state: parallel load, one mul/div step, or hold.
  always_comb begin
    acc_d  = acc_q;
    sreg_d = sreg_q;
    b_d    = b_q;
    if (load) begin
      acc_d  = acc_in;
      sreg_d = sreg_in;
      b_d    = b_in;
    end else if (step) begin
      if (is_div) begin
        acc_d  = div_fits ? div_diff : div_shift[WIDTH-1:0];
        sreg_d = {sreg_q[WIDTH-2:0], div_fits};
      end else begin
        acc_d  = mul_sum[WIDTH:1];
        sreg_d = {mul_sum[0], sreg_q[WIDTH-1:1]};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      sreg_q <= '0;
      b_q    <= '0;
    end else begin
      acc_q  <= acc_d;
      sreg_q <= sreg_d;
      b_q    <= b_d;
    end
  end

  assign acc_o  = acc_q;
  assign sreg_o = sreg_q;
  assign b_o    = b_q;

endmodule

// File: rtl/iterative_muldiv_unit.sv
// Multi-cycle multiply/divide unit producing {hi, lo} for the HI/LO commit path.
// Fixed latency of WIDTH+1 cycles from accept to out_valid.
// Build option: MULDIV_SIGNED_EN enables two's-complement MD_MULT/MD_DIV; otherwise
// those opcodes run as their unsigned counterparts.
module iterative_muldiv_unit
  import iterative_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  muldiv_state_t    state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             out_valid_q, out_valid_d;
  logic             div0_q, div0_d;

  muldiv_op_t       op_dec;
  logic             op_is_div;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] res_hi, res_lo;

  logic             core_load, core_step;
  logic [WIDTH-1:0] core_acc_in, core_sreg_in, core_b_in;
  logic [WIDTH-1:0] core_acc, core_sreg, core_b;

  assign op_dec    = muldiv_op_t'(op);
  assign op_is_div = (op_dec == MD_DIVU) || (op_dec == MD_DIV);

`ifdef MULDIV_SIGNED_EN
  logic               op_signed, a_neg, b_neg;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] prod_neg;

  assign op_signed = (op_dec == MD_MULT) || (op_dec == MD_DIV);
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign prod_neg  = -{core_acc, core_sreg};
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // Final result at DONE entry: optional sign fix, then divide-by-zero override.
  // A zero divisor already leaves the dividend magnitude in the remainder, so only lo
  // needs forcing; the remainder sign fix restores a signed dividend.
  always_comb begin
    res_hi = core_acc;
    res_lo = core_sreg;
`ifdef MULDIV_SIGNED_EN
    if (state_q == DIV) begin
      if (neg_res_q) res_lo = -core_sreg;
      if (neg_rem_q) res_hi = -core_acc;
    end else if (neg_res_q) begin
      res_hi = prod_neg[2*WIDTH-1:WIDTH];
      res_lo = prod_neg[WIDTH-1:0];
    end
`endif
    if ((state_q == DIV) && div0_q) res_lo = '1;
  end

  // FSM next state, counter, handshakes and core control.
  // The finished result is parked in the core during DONE and only copied to
  // hi_q/lo_q when consumed, so an abort in DONE leaves the previous result visible.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    out_valid_d  = out_valid_q;
    div0_d       = div0_q;
    core_load    = 1'b0;
    core_step    = 1'b0;
    core_acc_in  = '0;
    core_sreg_in = a_mag;
    core_b_in    = b_mag;
`ifdef MULDIV_SIGNED_EN
    neg_res_d    = neg_res_q;
    neg_rem_d    = neg_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && !abort) begin
          state_d   = op_is_div ? DIV : MUL;
          cnt_d     = CntW'(WIDTH);
          core_load = 1'b1;
          div0_d    = (b == '0);
`ifdef MULDIV_SIGNED_EN
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
`endif
        end
      end
      MUL, DIV: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d      = DONE;
          out_valid_d  = 1'b1;
          core_load    = 1'b1;
          core_acc_in  = res_hi;
          core_sreg_in = res_lo;
          core_b_in    = core_b;
        end else begin
          core_step = 1'b1;
          cnt_d     = cnt_q - CntW'(1);
        end
      end
      DONE: begin
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          hi_d        = core_acc;
          lo_d        = core_sreg;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and committed result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      div0_q      <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
      div0_q      <= div0_d;
`ifdef MULDIV_SIGNED_EN
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  iterative_muldiv_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (core_load),
    .step    (core_step),
    .is_div  (state_q == DIV),
    .acc_in  (core_acc_in),
    .sreg_in (core_sreg_in),
    .b_in    (core_b_in),
    .acc_o   (core_acc),
    .sreg_o  (core_sreg),
    .b_o     (core_b)
  );

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign hi        = out_valid_q ? core_acc : hi_q;
  assign lo        = out_valid_q ? core_sreg : lo_q;

endmodule
